// File: rtl/ysyx_22041405_wbu_pkg.sv
// Shared widths and result-offer bundle for the writeback unit.
// Imported by the WBU top, its scoreboard and the bench.
package ysyx_22041405_wbu_pkg;

    localparam int WBU_DATA_WIDTH = 32;
    localparam int WBU_ADDR_WIDTH = 5;

    localparam logic [1:0] STARVE_MAX = 2'd3;

    typedef struct packed {
        logic                      valid;
        logic [WBU_ADDR_WIDTH-1:0] rd;
        logic [WBU_DATA_WIDTH-1:0] data;
    } wb_offer_t;

endpackage

// File: rtl/ysyx_22041405_wbu_scoreboard.sv
// Register busy scoreboard: one bit per architectural register.
// Set wins over clear on the same index; bit 0 never goes busy.
module ysyx_22041405_scoreboard
    import ysyx_22041405_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = WBU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en_i,
    input  logic [ADDR_WIDTH-1:0] set_idx_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_idx_i,
    input  logic [ADDR_WIDTH-1:0] q1_idx_i,
    input  logic [ADDR_WIDTH-1:0] q2_idx_i,
    input  logic [ADDR_WIDTH-1:0] q3_idx_i,
    output logic                  q1_busy_o,
    output logic                  q2_busy_o,
    output logic                  q3_busy_o
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Queries see registered state only; an in-flight clear is not forwarded.
    assign q1_busy_o = busy_q[q1_idx_i];
    assign q2_busy_o = busy_q[q2_idx_i];
    assign q3_busy_o = busy_q[q3_idx_i];

endmodule

// File: rtl/ysyx_22041405_wbu.sv
// Writeback unit: arbitrates ALU/LSU results into a one-entry
// output register and tracks pending destinations for hazard stalls.
module ysyx_22041405_wbu
    import ysyx_22041405_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = WBU_DATA_WIDTH,
    parameter int ADDR_WIDTH = WBU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    input  logic [ADDR_WIDTH-1:0] chk_rd,
    output logic                  stall,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_rd,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    logic [1:0] starve_q;
    logic [1:0] starve_d;
    logic       grant_a_forced;
    logic       grant_b;

    logic [ADDR_WIDTH-1:0] out_rd_q;
    logic [ADDR_WIDTH-1:0] out_rd_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;

    logic sb_set;
    logic sb_clr;
    logic busy_rs1;
    logic busy_rs2;
    logic busy_rd;

    // B wins unless A has been starved long enough to force a grant.
    assign grant_a_forced = a_valid & (starve_q == STARVE_MAX);
    assign grant_b        = b_valid & !grant_a_forced;

    assign a_ready = !rst & a_valid & !grant_b;
    assign b_ready = !rst & b_valid & !grant_a_forced;

    always_comb begin
        starve_d = 2'd0;
        if (a_valid && !a_ready) begin
            starve_d = starve_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        out_rd_d   = '0;
        out_data_d = '0;
        if (b_ready) begin
            out_rd_d   = b_rd;
            out_data_d = b_data;
        end else if (a_ready) begin
            out_rd_d   = a_rd;
            out_data_d = a_data;
        end
        // x0 writes are squashed so the unconditional RF write is harmless.
        if (out_rd_d == '0) begin
            out_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_rd_q   <= '0;
            out_data_q <= '0;
        end else begin
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
        end
    end

    // Gating with rst drops a captured result if reset lands mid-commit.
    assign rf_waddr = rst ? '0 : out_rd_q;
    assign rf_wdata = rst ? '0 : out_data_q;

    assign sb_set = !rst & iss_valid & (iss_rd != '0);
    assign sb_clr = !rst & (out_rd_q != '0);

    ysyx_22041405_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (sb_set),
        .set_idx_i (iss_rd),
        .clr_en_i  (sb_clr),
        .clr_idx_i (out_rd_q),
        .q1_idx_i  (chk_rs1),
        .q2_idx_i  (chk_rs2),
        .q3_idx_i  (chk_rd),
        .q1_busy_o (busy_rs1),
        .q2_busy_o (busy_rs2),
        .q3_busy_o (busy_rd)
    );

    assign stall = !rst & (busy_rs1 | busy_rs2 | busy_rd);

endmodule
